demux_scan_ctrl: RTL

//  Upstream sequencer for the 1-to-8 behavioural demux. Loads an 8-bit pattern and sweeps

---
 rtl/demux_scan_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: sequencer for a 1-to-8 demux. Latches an 8-bit pattern and sweeps channels
// 0..7, holding each for DWELL cycles with en=1, then GAP cycles of en=0 (break-before-make).
// Optional build macro DEMUX_SCAN_MASK_EN adds mask_i (1 = skip channel), latched with pattern.
module demux_scan_ctrl #(
  parameter int unsigned DWELL = 4,  // 1..255
  parameter int unsigned GAP   = 1   // 0..255, 0 removes the gap state
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       repeat_i,
  input  logic [7:0] pattern_i,
`ifdef DEMUX_SCAN_MASK_EN
  input  logic [7:0] mask_i,
`endif
  output logic       in_o,
  output logic       en_o,
  output logic       s0_o,
  output logic       s1_o,
  output logic       s2_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {StIdle, StDrive, StGap, StDone} state_e;

  // Counters hold "cycles remaining minus one", so the final cycle is seen as zero.
  localparam logic [7:0] DwellLd = 8'(DWELL - 1);
  localparam logic [7:0] GapLd   = 8'(GAP - 1);

  state_e     state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] pat_q, pat_d;

  logic in_q, in_d;
  logic en_q, en_d;
  logic [2:0] sel_q, sel_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic       relatch;
  logic       advance;
  logic [3:0] nxt;  // {found, index} of next channel to drive
  logic [7:0] mask_new;  // mask as it will be latched on this edge
  logic [7:0] mask_cur;  // mask latched for the running sweep

`ifdef DEMUX_SCAN_MASK_EN
  logic [7:0] mask_q, mask_d;
  assign mask_new = mask_i;
  assign mask_cur = mask_q;
`else
  assign mask_new = 8'h00;
  assign mask_cur = 8'h00;
`endif

  // Lowest unmasked channel index >= from; bit 3 flags that one exists.
  function automatic logic [3:0] first_free(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (i >= int'(from) && !mask[i]) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  // Next-state logic for the sweep FSM, channel index, dwell/gap counter and latched data.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
`ifdef DEMUX_SCAN_MASK_EN
    mask_d  = mask_q;
`endif
    relatch = 1'b0;
    advance = 1'b0;
    nxt     = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          relatch = 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == 8'd0) begin
          if (GAP == 0) begin
            advance = 1'b1;
          end else begin
            state_d = StGap;
            cnt_d   = GapLd;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == 8'd0) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        if (repeat_i) begin
          relatch = 1'b1;
        end else begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Channel selection: a new sweep searches from 0 in the incoming mask, otherwise
    // the search continues past the current channel in the latched mask.
    if (relatch) begin
      pat_d = pattern_i;
`ifdef DEMUX_SCAN_MASK_EN
      mask_d = mask_i;
`endif
      nxt = first_free(mask_new, 4'd0);
    end else begin
      nxt = first_free(mask_cur, {1'b0, ch_q} + 4'd1);
    end

    if (relatch || advance) begin
      if (nxt[3]) begin
        state_d = StDrive;
        ch_d    = nxt[2:0];
        cnt_d   = DwellLd;
      end else begin
        state_d = StDone;
        ch_d    = relatch ? 3'd0 : ch_q;
        cnt_d   = 8'd0;
      end
    end

    // Abort: select holds its last value, latched data is left alone.
    if (stop_i && state_q != StIdle) begin
      state_d = StIdle;
      ch_d    = ch_q;
      cnt_d   = 8'd0;
      pat_d   = pat_q;
`ifdef DEMUX_SCAN_MASK_EN
      mask_d  = mask_q;
`endif
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    en_d   = (state_d == StDrive);
    in_d   = en_d & pat_d[ch_d];
    sel_d  = ch_d;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ch_q    <= 3'd0;
      cnt_q   <= 8'd0;
      pat_q   <= 8'd0;
`ifdef DEMUX_SCAN_MASK_EN
      mask_q  <= 8'd0;
`endif
      in_q    <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
`ifdef DEMUX_SCAN_MASK_EN
      mask_q  <= mask_d;
`endif
      in_q    <= in_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_o   = in_q;
  assign en_o   = en_q;
  assign s0_o   = sel_q[0];
  assign s1_o   = sel_q[1];
  assign s2_o   = sel_q[2];
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
